// File: rtl/ges_event_queue_if.sv
// Gesture event queue bus: raw gesture samples and display control in,
// buffered event pop port, status and LED indication out.
// master = producer/consumer side, slave = the event queue itself.
interface ges_event_queue_if #(
  parameter int GES_W      = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int LED_W      = 4,
  localparam int CODE_W    = $clog2(GES_W),
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
);
  logic              ges_valid;
  logic [GES_W-1:0]  ges_flags;
  logic              disp_mode;
  logic              clr_ovf;
  logic              evt_ready;
  logic              evt_valid;
  logic [CODE_W-1:0] evt_code;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              overflow;
  logic [LED_W-1:0]  led;

  modport master (
    output ges_valid, ges_flags, disp_mode, clr_ovf, evt_ready,
    input  evt_valid, evt_code, fifo_cnt, overflow, led
  );

  modport slave (
    input  ges_valid, ges_flags, disp_mode, clr_ovf, evt_ready,
    output evt_valid, evt_code, fifo_cnt, overflow, led
  );
endinterface

// File: rtl/ges_event_queue.sv
// Gesture event queue: encodes raw gesture flag samples into event codes
// (index of lowest set flag), buffers them in a first-word-fall-through
// FIFO with a valid/ready pop port, and shows the last accepted gesture
// on the LEDs for HOLD_CYC cycles.
// Optional build macro GES_DEDUP_EN: while the LED is showing a code, a
// repeat of that same code only extends the display and is not queued.
// The interface instance must be built with the same GES_W, FIFO_DEPTH
// and LED_W as this module.
module ges_event_queue #(
  parameter int GES_W      = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int LED_W      = 4,
  parameter int HOLD_CYC   = 50_000_000,
  localparam int CODE_W    = $clog2(GES_W)
) (
  input logic              sys_clk,
  input logic              sys_rst,
  ges_event_queue_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(HOLD_CYC);

  typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} led_state_t;

  // FIFO state
  logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  // LED FSM state
  led_state_t        state_q;
  logic [CODE_W-1:0] led_code_q;
  logic [TMR_W-1:0]  timer_q;

  // Datapath decisions
  logic [CODE_W-1:0] code_enc;
  logic              evt_hit;
  logic              dup;
  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic              drop;
  logic              full;
  logic              not_empty;
  logic [LED_W-1:0]  led_dec;

  // Priority encoder: scan high to low so the lowest set flag wins.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    code_enc = '0;
    for (int i = GES_W - 1; i >= 0; i--) begin
      if (bus.ges_flags[i]) code_enc = CODE_W'(i);
    end
  end

  assign evt_hit = bus.ges_valid && (bus.ges_flags != '0);

`ifdef GES_DEDUP_EN
  // A repeat of the code currently on display only extends the display.
  assign dup = (state_q == SHOW) && (code_enc == led_code_q);
`else
  assign dup = 1'b0;
`endif

  assign not_empty = (cnt_q != '0);
  assign full      = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign pop       = not_empty && bus.evt_ready;
  assign push_req  = evt_hit && !dup;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok   = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  // Next-state for pointers, occupancy and sticky overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // Set has priority over clear when both land in the same cycle.
    if (drop)             ovf_d = 1'b1;
    else if (bus.clr_ovf) ovf_d = 1'b0;
  end

  // FIFO control registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage write.
  // NOTE: the storage array has no reset; stale entries are never visible because evt_code is gated by occupancy.
  always_ff @(posedge sys_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= code_enc;
  end

  // LED FSM: latch the last accepted code and hold it for HOLD_CYC cycles.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      led_code_q <= '0;
      timer_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (evt_hit) begin
            led_code_q <= code_enc;
            timer_q    <= TMR_W'(HOLD_CYC - 1);
            state_q    <= SHOW;
          end
        end
        SHOW: begin
          if (evt_hit) begin
            led_code_q <= code_enc;
            timer_q    <= TMR_W'(HOLD_CYC - 1);
          end else if (timer_q == '0) begin
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // LED decode: one-hot of (code mod LED_W) or binary code, chosen live by disp_mode.
  always_comb begin
    logic [31:0] code_ext;
    code_ext = 32'(led_code_q);
    led_dec  = '0;
    for (int i = 0; i < LED_W; i++) begin
      if (bus.disp_mode) led_dec[i] = code_ext[i];
      else               led_dec[i] = ((code_ext % 32'(LED_W)) == 32'(i));
    end
  end

  assign bus.evt_valid = not_empty;
  assign bus.evt_code  = not_empty ? mem_q[rd_ptr_q] : '0;
  assign bus.fifo_cnt  = cnt_q;
  assign bus.overflow  = ovf_q;
  assign bus.led       = (state_q == SHOW) ? led_dec : '0;

endmodule

// File: tb/tb_ges_event_queue.sv
// Directed testbench for ges_event_queue (GES_W=8, FIFO_DEPTH=8, LED_W=4,
// HOLD_CYC=10). A vector table covers encode/decode/push/pop cycles; hand
// sequences cover LED hold time, overflow, full push+pop, dedup and reset.
module tb_ges_event_queue;

  localparam int GES_W      = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int LED_W      = 4;
  localparam int HOLD_CYC   = 10;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;

  int errors = 0;
  int checks = 0;

  ges_event_queue_if #(.GES_W(GES_W), .FIFO_DEPTH(FIFO_DEPTH), .LED_W(LED_W)) bus ();

  ges_event_queue #(
    .GES_W(GES_W), .FIFO_DEPTH(FIFO_DEPTH), .LED_W(LED_W), .HOLD_CYC(HOLD_CYC)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       v;
    logic [7:0] f;
    logic       m;
    logic       r;
    logic       ev;
    int         code;
    int         cnt;
    logic [3:0] led;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic v, input logic [7:0] f, input logic m,
                      input logic c, input logic r);
    @(negedge sys_clk);
    sys_rst       = 1'b0;
    bus.ges_valid = v;
    bus.ges_flags = f;
    bus.disp_mode = m;
    bus.clr_ovf   = c;
    bus.evt_ready = r;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input logic m);
    step(1'b0, 8'h00, m, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge sys_clk);
    sys_rst       = 1'b1;
    bus.ges_valid = 1'b0;
    bus.ges_flags = 8'h00;
    bus.disp_mode = 1'b0;
    bus.clr_ovf   = 1'b0;
    bus.evt_ready = 1'b0;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " evt_valid"}, int'(bus.evt_valid), 0);
    check({tag, " evt_code"},  int'(bus.evt_code),  0);
    check({tag, " fifo_cnt"},  int'(bus.fifo_cnt),  0);
    check({tag, " overflow"},  int'(bus.overflow),  0);
    check({tag, " led"},       int'(bus.led),       0);
  endtask

  // Push codes 0..7 back to back with no pop.
  task automatic fill_fifo();
    logic [7:0] f;
    for (int i = 0; i < 8; i++) begin
      f = 8'h01 << i;
      step(1'b1, f, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int n_led;
    int guard;
    int exp_order [8];

    // ---------------- reset ----------------
    apply_reset();
    apply_reset();
    check_reset_state("reset");

    // ---------------- first event and LED hold time ----------------
    step(1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
    check("t1 evt_valid", int'(bus.evt_valid), 1);
    check("t1 evt_code",  int'(bus.evt_code),  2);
    check("t1 fifo_cnt",  int'(bus.fifo_cnt),  1);
    check("t1 led first", int'(bus.led),       4'b0100);
    for (int i = 1; i < HOLD_CYC; i++) begin
      idle(1'b0);
      check($sformatf("t1 led hold %0d", i), int'(bus.led), 4'b0100);
    end
    idle(1'b0);
    check("t1 led off", int'(bus.led), 0);
    check("t1 still queued", int'(bus.fifo_cnt), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("t1 pop cnt",   int'(bus.fifo_cnt),  0);
    check("t1 pop valid", int'(bus.evt_valid), 0);

    // ---------------- table-driven encode / decode / push / pop ----------------
    //          v     flags  mode  ready  ev    code cnt  led
    tbl[0]  = '{1'b1, 8'hA0, 1'b1, 1'b0, 1'b1, 5, 1, 4'b0101}; // lowest bit 5, binary
    tbl[1]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 5, 1, 4'b0101}; // zero sample ignored
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5, 1, 4'b0010}; // one-hot 5 mod 4
    tbl[3]  = '{1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 7, 1, 4'b1000}; // push 7 + pop 5
    tbl[4]  = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 7, 2, 4'b0000}; // push 0, binary 0
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 0, 1, 4'b0001}; // pop 7
    tbl[6]  = '{1'b1, 8'h40, 1'b1, 1'b1, 1'b1, 6, 1, 4'b0110}; // push 6 + pop 0
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0, 0, 4'b0110}; // pop to empty
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0, 0, 4'b0110}; // ready while empty
    tbl[9]  = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 4, 1, 4'b0001}; // push+ready on empty
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 0, 4'b0001}; // pop 4
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v, tbl[i].f, tbl[i].m, 1'b0, tbl[i].r);
      check($sformatf("vec%0d evt_valid", i), int'(bus.evt_valid), int'(tbl[i].ev));
      check($sformatf("vec%0d evt_code", i),  int'(bus.evt_code),  tbl[i].code);
      check($sformatf("vec%0d fifo_cnt", i),  int'(bus.fifo_cnt),  tbl[i].cnt);
      check($sformatf("vec%0d overflow", i),  int'(bus.overflow),  0);
      check($sformatf("vec%0d led", i),       int'(bus.led),       int'(tbl[i].led));
    end

    // ---------------- overflow: 9 pushes into depth 8 ----------------
    fill_fifo();
    check("ovf cnt at 8",     int'(bus.fifo_cnt), 8);
    check("ovf not yet set",  int'(bus.overflow), 0);
    step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    check("ovf cnt after drop", int'(bus.fifo_cnt), 8);
    check("ovf set",            int'(bus.overflow), 1);
    check("ovf led takes drop", int'(bus.led),      4'b0010);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovf pop order %0d", i), int'(bus.evt_code), i);
      check($sformatf("ovf pop cnt %0d", i),   int'(bus.fifo_cnt), 8 - i);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    end
    check("ovf drained", int'(bus.fifo_cnt), 0);
    check("ovf sticky",  int'(bus.overflow), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("ovf cleared", int'(bus.overflow), 0);

    // ---------------- full: push and pop in the same cycle ----------------
    fill_fifo();
    step(1'b1, 8'h08, 1'b0, 1'b0, 1'b1);
    check("full pp cnt",  int'(bus.fifo_cnt), 8);
    check("full pp ovf",  int'(bus.overflow), 0);
    check("full pp head", int'(bus.evt_code), 1);
    // drop and clear in the same cycle: set wins
    step(1'b1, 8'h20, 1'b0, 1'b1, 1'b0);
    check("drop+clr ovf", int'(bus.overflow), 1);
    check("drop+clr cnt", int'(bus.fifo_cnt), 8);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("clr after drop", int'(bus.overflow), 0);
    exp_order = '{1, 2, 3, 4, 5, 6, 7, 3};
    for (int i = 0; i < 8; i++) begin
      check($sformatf("full pop order %0d", i), int'(bus.evt_code), exp_order[i]);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    end
    check("full drained", int'(bus.evt_valid), 0);

    // ---------------- repeated code, 4 cycles apart ----------------
    for (int i = 0; i < HOLD_CYC + 2; i++) idle(1'b0);
    check("dedup led idle", int'(bus.led), 0);
    n_led = 0;
    step(1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
    if (bus.led == 4'b1000) n_led++;
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      if (bus.led == 4'b1000) n_led++;
    end
    step(1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
    if (bus.led == 4'b1000) n_led++;
`ifdef GES_DEDUP_EN
    check("dedup fifo_cnt", int'(bus.fifo_cnt), 1);
`else
    check("dedup fifo_cnt", int'(bus.fifo_cnt), 2);
`endif
    check("dedup overflow", int'(bus.overflow), 0);
    guard = 0;
    while (bus.led != 4'b0000 && guard < 40) begin
      idle(1'b0);
      if (bus.led == 4'b1000) n_led++;
      guard++;
    end
    check("dedup led timeout", int'(guard < 40), 1);
    check("dedup led cycles", n_led, HOLD_CYC + 4);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("dedup drained", int'(bus.fifo_cnt), 0);

    // ---------------- reset mid-SHOW with events queued and overflow set ----------------
    fill_fifo();
    step(1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
    check("pre-rst ovf", int'(bus.overflow), 1);
    check("pre-rst led", int'(bus.led),      4'b0100);
    apply_reset();
    check_reset_state("mid rst");
    step(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
    check("post-rst evt_valid", int'(bus.evt_valid), 1);
    check("post-rst evt_code",  int'(bus.evt_code),  6);
    check("post-rst fifo_cnt",  int'(bus.fifo_cnt),  1);
    check("post-rst led",       int'(bus.led),       4'b0100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
